// File: rtl/bib3_pkg.sv
// Shared definitions for the bib3 ALU and its two-requester sharing controller.
// Instruction layout: op[8:6], a[5:3], b[2:0]; 4-bit result.
package bib3_pkg;

  localparam int BUYRUK_W = 9;
  localparam int SONUC_W  = 4;

  localparam logic [2:0] OP_0 = 3'd0;
  localparam logic [2:0] OP_1 = 3'd1;
  localparam logic [2:0] OP_2 = 3'd2;
  localparam logic [2:0] OP_3 = 3'd3;
  localparam logic [2:0] OP_4 = 3'd4;
  localparam logic [2:0] OP_5 = 3'd5;
  localparam logic [2:0] OP_6 = 3'd6;
  localparam logic [2:0] OP_7 = 3'd7;

  typedef enum logic [1:0] {
    BOS   = 2'd0,
    ISLEM = 2'd1,
    BEKLE = 2'd2
  } durum_t;

endpackage

// File: rtl/rr_hakem_2.sv
// Two-way round-robin grant: a lone request always wins,
// on contention the requester that did not win last time wins.
module rr_hakem_2 (
  input  logic [1:0] gecerli,
  input  logic       son_kazanan,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (gecerli)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = son_kazanan ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/bib3_paylasim_denetleyici.sv
// Shares one combinational bib3 ALU between two requesters and returns
// each result tagged with its requester id over a valid/ready output.
module bib3_paylasim_denetleyici #(
  parameter int BUYRUK_W = bib3_pkg::BUYRUK_W,
  parameter int SONUC_W  = bib3_pkg::SONUC_W,
  parameter int SAYAC_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                istek0_gecerli,
  input  logic [BUYRUK_W-1:0] istek0_buyruk,
  output logic                istek0_hazir,
  input  logic                istek1_gecerli,
  input  logic [BUYRUK_W-1:0] istek1_buyruk,
  output logic                istek1_hazir,
  output logic [BUYRUK_W-1:0] alu_buyruk,
  input  logic [SONUC_W-1:0]  alu_sonuc,
  output logic                cikis_gecerli,
  output logic [SONUC_W-1:0]  cikis_sonuc,
  output logic                cikis_kaynak,
  input  logic                cikis_hazir,
  output logic [SAYAC_W-1:0]  tamamlanan
);

  import bib3_pkg::*;

  durum_t              r_durum;
  durum_t              w_sonraki;
  logic [BUYRUK_W-1:0] r_alu_buyruk;
  logic                r_cikis_gecerli;
  logic [SONUC_W-1:0]  r_cikis_sonuc;
  logic                r_cikis_kaynak;
  logic [SAYAC_W-1:0]  r_tamamlanan;
  logic                r_son_kazanan;
  logic                r_kaynak;
  logic [1:0]          w_grant;
  logic                w_hazir0;
  logic                w_hazir1;
  logic                w_kabul;
  logic                w_teslim;

  rr_hakem_2 u_hakem (
    .gecerli     ({istek1_gecerli, istek0_gecerli}),
    .son_kazanan (r_son_kazanan),
    .grant       (w_grant)
  );

  always_comb begin
    w_sonraki = r_durum;
    w_hazir0  = 1'b0;
    w_hazir1  = 1'b0;
    w_teslim  = 1'b0;
    unique case (r_durum)
      BOS: begin
        // reset beats a same-cycle accept
        w_hazir0 = w_grant[0] & ~rst;
        w_hazir1 = w_grant[1] & ~rst;
        if (w_hazir0 | w_hazir1)
          w_sonraki = ISLEM;
      end
      ISLEM: w_sonraki = BEKLE;
      BEKLE: begin
        w_teslim = cikis_hazir;
        if (cikis_hazir)
          w_sonraki = BOS;
      end
      default: w_sonraki = BOS;
    endcase
  end

  assign w_kabul = w_hazir0 | w_hazir1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_durum         <= BOS;
      r_alu_buyruk    <= '0;
      r_cikis_gecerli <= 1'b0;
      r_cikis_sonuc   <= '0;
      r_cikis_kaynak  <= 1'b0;
      r_tamamlanan    <= '0;
      r_son_kazanan   <= 1'b1;
      r_kaynak        <= 1'b0;
    end else begin
      r_durum <= w_sonraki;
      if (w_kabul) begin
        r_alu_buyruk  <= w_hazir1 ? istek1_buyruk
                                  : istek0_buyruk;
        r_kaynak      <= w_hazir1;
        r_son_kazanan <= w_hazir1;
      end
      if (r_durum == ISLEM) begin
        r_cikis_sonuc   <= alu_sonuc;
        r_cikis_kaynak  <= r_kaynak;
        r_cikis_gecerli <= 1'b1;
      end
      if (w_teslim) begin
        r_cikis_gecerli <= 1'b0;
        r_tamamlanan    <= r_tamamlanan + 1'b1;
      end
    end
  end

  assign istek0_hazir  = w_hazir0;
  assign istek1_hazir  = w_hazir1;
  assign alu_buyruk    = r_alu_buyruk;
  assign cikis_gecerli = r_cikis_gecerli;
  assign cikis_sonuc   = r_cikis_sonuc;
  assign cikis_kaynak  = r_cikis_kaynak;
  assign tamamlanan    = r_tamamlanan;

endmodule
